// File: rtl/pirdsp_pkg.sv
// Shared definitions for the PIRDSP MAC back end: mode encoding, lane geometry,
// datapath widths and FSM states.
package pirdsp_pkg;

    localparam int PROD_W = 32;
    localparam int ACC_W  = 48;
    localparam int CNT_W  = 8;

    // Adder is built from four 12-bit segments; lane seams fall on segment edges
    localparam int SEG_W   = 12;
    localparam int NUM_SEG = ACC_W / SEG_W;

    localparam int LANES_8  = 2;
    localparam int LANES_4  = 4;
    localparam int LANE_W_8 = 24;
    localparam int LANE_W_4 = 12;
    localparam int PROD_W_8 = 16;
    localparam int PROD_W_4 = 8;

    typedef enum logic [2:0] {
        MODE_16 = 3'b001,
        MODE_8  = 3'b010,
        MODE_4  = 3'b100
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    function automatic mode_e decode_mode(input logic h2, input logic h1, input logic h0);
        if (h2)      return MODE_4;
        else if (h1) return MODE_8;
        else if (h0) return MODE_16;
        return MODE_16;
    endfunction

endpackage

// File: rtl/pirdsp_simd_accumulator_if.sv
// Product-in / result-out bus of the SIMD accumulator.
interface pirdsp_simd_accumulator_if;
    import pirdsp_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] C;
    logic              A_sign;
    logic              B_sign;
    logic              HALF_0;
    logic              HALF_1;
    logic              HALF_2;
    logic [CNT_W-1:0]  len;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  acc_out;
    logic [2:0]        out_mode;
    logic [3:0]        ovf;

    modport master (
        output in_valid, C, A_sign, B_sign, HALF_0, HALF_1, HALF_2, len, out_ready,
        input  in_ready, out_valid, acc_out, out_mode, ovf
    );

    modport slave (
        input  in_valid, C, A_sign, B_sign, HALF_0, HALF_1, HALF_2, len, out_ready,
        output in_ready, out_valid, acc_out, out_mode, ovf
    );

endinterface

// File: rtl/pirdsp_simd_add48.sv
// Lane-partitioned 48-bit adder: extends packed products to lane width and adds
// them to the accumulator with carries killed at lane seams.
module pirdsp_simd_add48
    import pirdsp_pkg::*;
(
    input  mode_e             mode,
    input  logic              sgn,
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  ext,
    output logic [ACC_W-1:0]  sum,
    output logic [3:0]        lane_ovf
);

    logic [NUM_SEG-1:0]           kill;
    logic [NUM_SEG-1:0][SEG_W:0]  seg;
    logic [NUM_SEG-1:0]           seg_ovf;
    logic                         carry;

    always_comb begin
        ext = '0;
        case (mode)
            MODE_4:
                for (int i = 0; i < LANES_4; i++)
                    ext[LANE_W_4*i +: LANE_W_4] =
                        {{(LANE_W_4-PROD_W_4){sgn & prod[PROD_W_4*i+PROD_W_4-1]}},
                         prod[PROD_W_4*i +: PROD_W_4]};
            MODE_8:
                for (int i = 0; i < LANES_8; i++)
                    ext[LANE_W_8*i +: LANE_W_8] =
                        {{(LANE_W_8-PROD_W_8){sgn & prod[PROD_W_8*i+PROD_W_8-1]}},
                         prod[PROD_W_8*i +: PROD_W_8]};
            default:
                ext = {{(ACC_W-PROD_W){sgn & prod[PROD_W-1]}}, prod};
        endcase
    end

    // Seams at 12 and 36 exist only in 4x4; the seam at 24 in both 8x8 and 4x4
    assign kill = {mode == MODE_4, (mode == MODE_4) || (mode == MODE_8), mode == MODE_4, 1'b1};

    always_comb begin
        seg     = '0;
        sum     = '0;
        seg_ovf = '0;
        carry   = 1'b0;
        for (int k = 0; k < NUM_SEG; k++) begin
            seg[k] = {1'b0, acc[SEG_W*k +: SEG_W]} + {1'b0, ext[SEG_W*k +: SEG_W]}
                   + {{SEG_W{1'b0}}, carry & ~kill[k]};
            carry  = seg[k][SEG_W];
            sum[SEG_W*k +: SEG_W] = seg[k][SEG_W-1:0];
            seg_ovf[k] = sgn ? ((acc[SEG_W*k+SEG_W-1] == ext[SEG_W*k+SEG_W-1]) &&
                                (seg[k][SEG_W-1] != acc[SEG_W*k+SEG_W-1]))
                             : seg[k][SEG_W];
        end
    end

    // Only the segment holding a lane's MSB reports that lane's overflow
    always_comb begin
        case (mode)
            MODE_4:  lane_ovf = seg_ovf;
            MODE_8:  lane_ovf = {2'b00, seg_ovf[3], seg_ovf[1]};
            default: lane_ovf = {3'b000, seg_ovf[3]};
        endcase
    end

endmodule

// File: rtl/pirdsp_simd_accumulator.sv
// SIMD MAC back end: accumulates a burst of packed products per lane and holds
// the result on a valid/ready output until consumed.
module pirdsp_simd_accumulator
    import pirdsp_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    pirdsp_simd_accumulator_if.slave   bus
);

    state_e           state, state_nxt;
    mode_e            mode_q, mode_in, mode_op;
    logic             sgn_q, sgn_op;
    logic [CNT_W-1:0] len_q, len_eff, cnt, cnt_inc;
    logic [ACC_W-1:0] acc_q, ext, sum;
    logic [3:0]       ovf_q, lane_ovf;
    logic             accept;

    assign mode_in = decode_mode(bus.HALF_2, bus.HALF_1, bus.HALF_0);
    assign len_eff = (bus.len == '0) ? CNT_W'(1) : bus.len;
    assign accept  = bus.in_valid && (state != ST_HOLD);
    assign cnt_inc = cnt + CNT_W'(1);

    // The first beat of a burst is decoded from the live inputs, later ones from the latch
    assign mode_op = (state == ST_IDLE) ? mode_in : mode_q;
    assign sgn_op  = (state == ST_IDLE) ? (bus.A_sign | bus.B_sign) : sgn_q;

    pirdsp_simd_add48 u_add (
        .mode     (mode_op),
        .sgn      (sgn_op),
        .acc      (acc_q),
        .prod     (bus.C),
        .ext      (ext),
        .sum      (sum),
        .lane_ovf (lane_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = (len_eff == CNT_W'(1)) ? ST_HOLD : ST_ACCUM;
            ST_ACCUM: if (accept && (cnt_inc == len_q)) state_nxt = ST_HOLD;
            ST_HOLD:  if (bus.out_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state != ST_HOLD);
        bus.out_valid = (state == ST_HOLD);
        bus.acc_out   = acc_q;
        bus.ovf       = ovf_q;
        bus.out_mode  = mode_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_16;
            sgn_q  <= 1'b0;
            len_q  <= '0;
            cnt    <= '0;
            acc_q  <= '0;
            ovf_q  <= '0;
        end else if (accept) begin
            if (state == ST_IDLE) begin
                mode_q <= mode_in;
                sgn_q  <= bus.A_sign | bus.B_sign;
                len_q  <= len_eff;
                cnt    <= CNT_W'(1);
                acc_q  <= ext;
                ovf_q  <= '0;
            end else begin
                cnt    <= cnt_inc;
                acc_q  <= sum;
                ovf_q  <= ovf_q | lane_ovf;
            end
        end
    end

endmodule
